// File: rtl/load_interlock_pkg.sv
// Shared DLX decode definitions: opcodes, instruction fields, interlock FSM states.
// Pure declarations, no logic and no latency.
// Not applicable for backpressure; consumed by the interlock and its decoder.
package load_interlock_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [4:0] REG_R0 = 5'd0;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] low;
    } dlx_ir_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID-stage instruction that reads the register an EX-stage LW is loading.
// Purely combinational, zero latency.
// No backpressure; the result feeds the interlock FSM directly.
module load_use_detect
    import load_interlock_pkg::*;
(
    input  logic [31:0] IRid,
    input  logic [31:0] IRex,
    output logic        load_use
);

    dlx_ir_t id;
    dlx_ir_t ex;
    logic    reads_rs;
    logic    reads_rt;
    logic    unused_fields;

    assign id = IRid;
    assign ex = IRex;

    // SW store data comes through rt but is served by the EX-stage load bypass,
    // so only SPECIAL and branches count as rt readers.
    assign reads_rs = !((id.op == OP_J) || (id.op == OP_JAL) || (IRid == 32'h0));
    assign reads_rt = (id.op == OP_SPECIAL) || (id.op == OP_BEQ) || (id.op == OP_BNE);

    assign load_use = (ex.op == OP_LW) && (ex.rt != REG_R0) &&
                      ((reads_rs && (id.rs == ex.rt)) || (reads_rt && (id.rt == ex.rt)));

    assign unused_fields = ^{id.low, ex.rs, ex.low};

endmodule

// File: rtl/load_interlock.sv
// Pipeline interlock: load-use bubbles, data-memory wait holds, sticky memory timeout.
// Stall/bubble/hold decisions are combinational (same cycle); stall_count updates on the edge.
// Memory not ready freezes EX/MEM..MEM/WB and upstream; too long a wait latches mem_err until reset.
module load_interlock
    import load_interlock_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      IRid,
    input  logic [31:0]      IRex,
    input  logic [31:0]      IRmem,
    input  logic             mem_ready,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             hold_mem,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    dlx_ir_t           mem_ir;
    logic              mem_busy;
    logic              load_use;
    logic              stall_c, bubble_c, hold_c, err_c;
    logic              unused_mem_fields;

    assign mem_ir            = IRmem;
    assign mem_busy          = is_mem_op(mem_ir.op) && !mem_ready;
    assign unused_mem_fields = ^{mem_ir.rs, mem_ir.rt, mem_ir.low};

    load_use_detect u_load_use_detect (
        .IRid     (IRid),
        .IRex     (IRex),
        .load_use (load_use)
    );

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        hold_c   = 1'b0;
        err_c    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    stall_c = 1'b1;
                    hold_c  = 1'b1;
                    state_d = ST_MEM_WAIT;
                end else if (load_use) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    // Access completes: behave exactly like RUN for this cycle.
                    wait_d  = '0;
                    state_d = ST_RUN;
                    if (load_use) begin
                        stall_c  = 1'b1;
                        bubble_c = 1'b1;
                    end
                end else begin
                    stall_c = 1'b1;
                    hold_c  = 1'b1;
                    wait_d  = wait_q + WAIT_W'(1);
                    if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                stall_c = 1'b1;
                hold_c  = 1'b1;
                err_c   = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
                wait_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Reset must silence the outputs at once, even while RUN sees a busy memory.
    assign stall_if  = rst_n & stall_c;
    assign stall_id  = rst_n & stall_c;
    assign bubble_ex = rst_n & bubble_c;
    assign hold_mem  = rst_n & hold_c;
    assign mem_err   = rst_n & err_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall_if && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_load_interlock.sv
// Randomized and directed bench for load_interlock with a queue-based scoreboard.
module tb_load_interlock;

    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 16;
    localparam int CMAX        = (1 << CNT_W) - 1;

    localparam logic [5:0] SPECIAL = 6'h00, J = 6'h02, JAL = 6'h03, BEQ = 6'h04,
                           BNE = 6'h05, ADDI = 6'h08, LW = 6'h23, SW = 6'h2b;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      IRid = '0, IRex = '0, IRmem = '0;
    logic             mem_ready = 1'b1;
    logic             stall_if, stall_id, bubble_ex, hold_mem, mem_err;
    logic [CNT_W-1:0] stall_count;

    always #5 clk = ~clk;

    load_interlock #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .IRid        (IRid),
        .IRex        (IRex),
        .IRmem       (IRmem),
        .mem_ready   (mem_ready),
        .stall_if    (stall_if),
        .stall_id    (stall_id),
        .bubble_ex   (bubble_ex),
        .hold_mem    (hold_mem),
        .mem_err     (mem_err),
        .stall_count (stall_count)
    );

    typedef struct {
        logic [4:0]       o;
        logic [CNT_W-1:0] cnt;
        string            tag;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    // Reference model state: waiting on memory, consecutive low cycles, error, stall total.
    bit m_wait = 0;
    bit m_err  = 0;
    int m_low  = 0;
    int m_cnt  = 0;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic bit ref_load_use(input logic [31:0] id, input logic [31:0] ex);
        bit rrs, rrt;
        rrs = !(id[31:26] == J || id[31:26] == JAL || id == 32'h0);
        rrt = (id[31:26] == SPECIAL || id[31:26] == BEQ || id[31:26] == BNE);
        return (ex[31:26] == LW) && (ex[20:16] != 5'd0) &&
               ((rrs && id[25:21] == ex[20:16]) || (rrt && id[20:16] == ex[20:16]));
    endfunction

    task automatic cyc(input logic [31:0] id, input logic [31:0] ex, input logic [31:0] mem,
                       input bit rdy, input bit rst, input string tag);
        bit   s, b, h, e;
        int   cnt_now;
        exp_t x;
        @(posedge clk);
        #2;
        IRid = id; IRex = ex; IRmem = mem; mem_ready = rdy; rst_n = rst;
        s = 0; b = 0; h = 0; e = 0;
        if (!rst) begin
            m_wait = 0; m_low = 0; m_err = 0; m_cnt = 0;
            cnt_now = 0;
        end else begin
            cnt_now = m_cnt;
            if (m_err) begin
                s = 1; h = 1; e = 1;
            end else if (m_wait && !rdy) begin
                s = 1; h = 1;
                m_low++;
                if (m_low > MEM_TIMEOUT) m_err = 1;
            end else begin
                m_wait = 0; m_low = 0;
                if ((mem[31:26] == LW || mem[31:26] == SW) && !rdy) begin
                    s = 1; h = 1; m_wait = 1; m_low = 1;
                end else if (ref_load_use(id, ex)) begin
                    s = 1; b = 1;
                end
            end
            if (s && m_cnt < CMAX) m_cnt++;
        end
        x.o   = {s, s, b, h, e};
        x.cnt = CNT_W'(cnt_now);
        x.tag = tag;
        sb.push_back(x);
    endtask

    function automatic logic [31:0] rand_ir(input bit bias_lw);
        logic [5:0] ops [8];
        ops = '{SPECIAL, J, JAL, BEQ, BNE, ADDI, LW, SW};
        if ($urandom_range(0, 9) == 0) return 32'h0;
        if (bias_lw && $urandom_range(0, 1) == 1)
            return mk(LW, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom));
        return mk(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 16'($urandom));
    endfunction

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    initial begin
        exp_t       x;
        logic [4:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x   = sb.pop_front();
                act = {stall_if, stall_id, bubble_ex, hold_mem, mem_err};
                n_chk++;
                if (act !== x.o || stall_count !== x.cnt) begin
                    n_fail++;
                    $display("FAIL %s: {stall_if,stall_id,bubble_ex,hold_mem,mem_err}=%b stall_count=%0d, expected %b / %0d",
                             x.tag, act, stall_count, x.o, x.cnt);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] nop, add_r5, lw_r5, sw_r5, lw_r0, add_r0, j_r5, beq_r5, lw_mem, sw_mem;
        nop    = 32'h0;
        add_r5 = mk(SPECIAL, 5'd5, 5'd2, 16'h1820);
        lw_r5  = mk(LW, 5'd1, 5'd5, 16'h0010);
        sw_r5  = mk(SW, 5'd1, 5'd5, 16'h0004);
        lw_r0  = mk(LW, 5'd1, 5'd0, 16'h0008);
        add_r0 = mk(SPECIAL, 5'd0, 5'd3, 16'h2020);
        j_r5   = mk(J, 5'd5, 5'd5, 16'h0040);
        beq_r5 = mk(BEQ, 5'd3, 5'd5, 16'h0002);
        lw_mem = mk(LW, 5'd2, 5'd7, 16'h0000);
        sw_mem = mk(SW, 5'd2, 5'd7, 16'h0000);

        cyc(nop, nop, nop, 1, 0, "reset_idle");
        cyc(add_r5, lw_r5, lw_mem, 0, 0, "reset_busy_inputs");

        cyc(add_r5, lw_r5, nop, 1, 1, "load_use_add");
        cyc(nop, nop, nop, 1, 1, "after_load_use");
        cyc(sw_r5, lw_r5, nop, 1, 1, "sw_store_data_no_stall");
        cyc(add_r0, lw_r0, nop, 1, 1, "r0_no_stall");
        cyc(j_r5, lw_r5, nop, 1, 1, "jump_no_stall");
        cyc(beq_r5, lw_r5, nop, 1, 1, "beq_rt_stall");

        for (int i = 0; i < 3; i++) cyc(add_r5, lw_r5, lw_mem, 0, 1, "mem_wait_hold");
        cyc(add_r5, lw_r5, lw_mem, 1, 1, "wait_end_bubble");
        cyc(nop, nop, nop, 1, 1, "after_wait");

        for (int i = 0; i < 20; i++) cyc(nop, nop, sw_mem, 0, 1, "timeout");
        for (int i = 0; i < 3; i++) cyc(add_r5, lw_r5, nop, 1, 1, "err_sticky");
        cyc(nop, nop, sw_mem, 0, 0, "reset_from_err");
        cyc(add_r5, lw_r5, nop, 1, 1, "post_reset_run");

        // Reset pulse in the middle of a memory wait.
        cyc(nop, nop, lw_mem, 0, 1, "wait_before_reset");
        cyc(nop, nop, lw_mem, 0, 1, "wait_before_reset");
        cyc(nop, nop, lw_mem, 0, 0, "reset_mid_wait");
        cyc(nop, nop, nop, 1, 1, "post_reset_idle");

        for (int i = 0; i < 3000; i++)
            cyc(rand_ir(0), rand_ir(1), rand_ir(0), $urandom_range(0, 3) != 0,
                $urandom_range(0, 199) != 0, "random");

        cyc(nop, nop, nop, 1, 0, "reset_before_saturate");
        for (int i = 0; i < 17; i++) cyc(nop, nop, sw_mem, 0, 1, "enter_err");
        for (int i = 0; i < 65600; i++) cyc(nop, nop, nop, 1, 1, "saturate");

        repeat (4) @(negedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left in scoreboard, expected 0", sb.size());
        end else begin
            n_pass++;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
